pipe_adder: RTL and testbench



---
 rtl/pipe_adder_pkg.sv | 13 +
 rtl/adder_chunk.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipe_adder.sv | 113 +++++++++++
 tb/tb_pipe_adder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared defaults and chunk sizing for the pipelined adder.
// Imported by the RTL and the bench so both derive CHUNK the same way.
package pipe_adder_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned STAGES_DEF = 4;

    // Bits added by one pipeline stage; a zero stage count yields 0 so elaboration can report it.
    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// cmsb is the carry into the top bit, used for signed overflow at the MSB chunk.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell, the building block of adder_chunk.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit ripple-carry adder: one CHUNK per stage, registered carry, valid/ready both sides.
// Define PIPE_ADDER_SUB_EN to add the in_sub port (computes A + ~B + 1).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);
    localparam int unsigned VW    = STAGES + 1;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: STAGES=%0d must be >= 1 and divide WIDTH=%0d", STAGES, WIDTH);
    end

    logic              w_adv;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;
    logic [STAGES:0]   r_vld;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_cmsb;
    logic              w_unused_cmsb;
    logic              r_cout;
    logic              r_ovf;

    // Subtraction folds into the operand beat before it enters the pipe.
`ifdef PIPE_ADDER_SUB_EN
    assign w_b_eff   = in_sub ? ~in_b : in_b;
    assign w_cin_eff = in_sub | in_cin;
`else
    assign w_b_eff   = in_b;
    assign w_cin_eff = in_cin;
`endif

    // Whole pipe moves in lockstep; a held output freezes every register.
    assign w_adv     = ~r_vld[STAGES] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES];
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

    // Only the MSB stage's carry-in matters for overflow.
    assign w_unused_cmsb = ^w_cmsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_c    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_vld  <= VW'({r_vld, in_valid});
            r_c    <= STAGES'({w_cout, w_cin_eff});
            r_cout <= w_cout[STAGES-1];
            r_ovf  <= w_cout[STAGES-1] ^ w_cmsb[STAGES-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned AW = (k + 1) * CHUNK;
        localparam int unsigned SW = (STAGES - k) * CHUNK;

        // Operand skew line (k+1 deep) and result de-skew line (STAGES-k deep).
        logic [k:0][CHUNK-1:0]          r_a_dly;
        logic [k:0][CHUNK-1:0]          r_b_dly;
        logic [STAGES-1-k:0][CHUNK-1:0] r_s_dly;
        logic [CHUNK-1:0]               w_sum;

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (r_a_dly[k]),
            .b    (r_b_dly[k]),
            .cin  (r_c[k]),
            .sum  (w_sum),
            .cout (w_cout[k]),
            .cmsb (w_cmsb[k])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_dly <= '0;
                r_b_dly <= '0;
                r_s_dly <= '0;
            end else if (w_adv) begin
                r_a_dly <= AW'({r_a_dly, in_a[k*CHUNK +: CHUNK]});
                r_b_dly <= AW'({r_b_dly, w_b_eff[k*CHUNK +: CHUNK]});
                r_s_dly <= SW'({r_s_dly, w_sum});
            end
        end

        assign out_sum[k*CHUNK +: CHUNK] = r_s_dly[STAGES-1-k];
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed cases, latency, stall, mid-flight reset,
// random backpressure on a 32/4 instance and an exhaustive sweep on a 4/2 instance.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int unsigned W32 = WIDTH_DEF;
    localparam int unsigned S32 = STAGES_DEF;
    localparam int unsigned W4  = 4;
    localparam int unsigned S4  = 2;

    typedef struct packed { logic [W32-1:0] sum; logic cout; logic ovf; } exp32_t;
    typedef struct packed { logic [W4-1:0]  sum; logic cout; logic ovf; } exp4_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           v32 = 1'b0, cin32 = 1'b0, ordy32 = 1'b1;
    logic [W32-1:0] a32 = '0, b32 = '0;
    logic           rdy32, ov32, cout32, ovf32;
    logic [W32-1:0] os32;
    logic           v4 = 1'b0, cin4 = 1'b0, ordy4 = 1'b1;
    logic [W4-1:0]  a4 = '0, b4 = '0;
    logic           rdy4, ov4, cout4, ovf4;
    logic [W4-1:0]  os4;
`ifdef PIPE_ADDER_SUB_EN
    logic           sub32 = 1'b0;
    logic           sub4  = 1'b0;
`endif

    exp32_t q32[$];
    exp4_t  q4[$];
    exp32_t e32;
    exp4_t  e4;
    int     n_vec = 0, n_err = 0, n_out32 = 0, n_out4 = 0, base;
    logic   done;

    pipe_adder #(.WIDTH(W32), .STAGES(S32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .in_a(a32), .in_b(b32), .in_cin(cin32),
`ifdef PIPE_ADDER_SUB_EN
        .in_sub(sub32),
`endif
        .out_valid(ov32), .out_ready(ordy32), .out_sum(os32), .out_cout(cout32), .out_ovf(ovf32)
    );

    pipe_adder #(.WIDTH(W4), .STAGES(S4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_cin(cin4),
`ifdef PIPE_ADDER_SUB_EN
        .in_sub(sub4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .out_sum(os4), .out_cout(cout4), .out_ovf(ovf4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp32_t model32(input logic [W32-1:0] a, input logic [W32-1:0] b,
                                       input logic cin, input logic sub);
        logic [W32-1:0] bb;
        logic [W32:0]   s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W32{1'b0}}, sub | cin};
        return '{sum: s[W32-1:0], cout: s[W32],
                 ovf: (a[W32-1] == bb[W32-1]) && (s[W32-1] != a[W32-1])};
    endfunction

    function automatic exp4_t model4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic cin);
        logic [W4:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W4{1'b0}}, cin};
        return '{sum: s[W4-1:0], cout: s[W4],
                 ovf: (a[W4-1] == b[W4-1]) && (s[W4-1] != a[W4-1])};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the beat is taken.
    task automatic send32(input logic [W32-1:0] a, input logic [W32-1:0] b, input logic cin, input logic sub);
        int t = 0;
        a32 = a; b32 = b; cin32 = cin; v32 = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        sub32 = sub;
`endif
        @(negedge clk);
        while (!rdy32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rdy32) check_val("accept32_timeout", rdy32, 1);
        else q32.push_back(model32(a, b, cin, sub));
        @(posedge clk);
        #1;
        v32 = 1'b0;
    endtask

    task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic cin);
        int t = 0;
        a4 = a; b4 = b; cin4 = cin; v4 = 1'b1;
        @(negedge clk);
        while (!rdy4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rdy4) check_val("accept4_timeout", rdy4, 1);
        else q4.push_back(model4(a, b, cin));
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() != 0 || q4.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_left", q32.size() + q4.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output side of the scoreboards: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n && ov32 && ordy32) begin
            n_out32++;
            if (q32.size() == 0) check_val("extra_out32", ov32, 0);
            else begin
                e32 = q32.pop_front();
                check_val("sum32", os32, e32.sum);
                check_val("cout32", cout32, e32.cout);
                check_val("ovf32", ovf32, e32.ovf);
            end
        end
        if (rst_n && ov4 && ordy4) begin
            n_out4++;
            if (q4.size() == 0) check_val("extra_out4", ov4, 0);
            else begin
                e4 = q4.pop_front();
                check_val("sum4", os4, e4.sum);
                check_val("cout4", cout4, e4.cout);
                check_val("ovf4", ovf4, e4.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got t=%0t expected finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", ov32, 0);
        check_val("rst_sum", os32, 0);
        check_val("rst_cout", cout32, 0);
        check_val("rst_ovf", ovf32, 0);
        check_val("rst_ready", rdy32, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat: valid exactly STAGES edges after acceptance, for one cycle.
        send32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        for (int s = 0; s <= int'(S32) + 1; s++) begin
            @(negedge clk);
            check_val("latency_valid", ov32, (s == int'(S32)));
        end
        @(posedge clk);
        #1;

        send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();

        // Back-to-back beats with the first result held for five cycles.
        base   = n_out32;
        ordy32 = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send32(W32'(i), W32'(i * 3), 1'b0, 1'b0);
            begin
                int t = 0;
                while (!ov32 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check_val("stall_valid", ov32, 1);
                for (int c = 0; c < 5; c++) begin
                    check_val("stall_ready", rdy32, 0);
                    check_val("stall_sum", os32, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                ordy32 = 1'b1;
            end
        join
        drain();
        check_val("b2b_count", n_out32 - base, 8);

        // Reset with three beats in flight: all of them must vanish.
        for (int i = 0; i < 3; i++) send32(W32'(100 + i), W32'(1), 1'b0, 1'b0);
        rst_n = 1'b0;
        q32.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_val("inrst_valid", ov32, 0);
            check_val("inrst_sum", os32, 0);
            check_val("inrst_ready", rdy32, 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < int'(S32) + 2; c++) begin
            @(negedge clk);
            check_val("postrst_valid", ov32, 0);
            check_val("postrst_ready", rdy32, 1);
        end
        @(posedge clk);
        #1;
        send32(W32'(5), W32'(6), 1'b0, 1'b0);
        drain();

`ifdef PIPE_ADDER_SUB_EN
        send32(W32'(3), W32'(5), 1'b0, 1'b1);
        send32(W32'(5), W32'(3), 1'b0, 1'b1);
        send32(W32'(5), W32'(3), 1'b1, 1'b1);
        send32(32'h8000_0000, W32'(1), 1'b0, 1'b1);
        drain();
`endif

        // Random operands under random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send32(W32'($urandom), W32'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ordy32 = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        ordy32 = 1'b1;
        drain();

        // Exhaustive 4-bit sweep, back-to-back.
        base = n_out4;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    send4(W4'(a), W4'(b), 1'(c));
        drain();
        check_val("sweep_count", n_out4 - base, 512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
